jls_stream_byteizer: RTL

Sits directly downstream of jls_encoder. It takes the encoder's 16-bit output word stream (o_e/o_data/o_last, which has no backpressure) and buffers it in an internal FIFO. It then serializes each word into two bytes, high byte first, on a valid/ready byte interface that can stall. It is the boundary between the free-running encoder and a throttled sink such as a UART, a bus DMA or a file writer.

---
 rtl/jls_stream_byteizer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/jls_stream_byteizer.sv
// JPEG-LS word-to-byte stream adapter: FIFO-buffers 16-bit encoder words and emits them MSB-first on a valid/ready byte port.
// Optional JLS_BYTEIZER_FRAME_CNT_EN adds a per-stream byte counter with a done pulse.
module jls_stream_byteizer #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_e,
   input  logic [15:0]   i_data,
   input  logic          i_last,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [7:0]    o_byte,
   output logic          o_last,
   output logic [AW:0]   o_level,
   output logic          o_overflow
`ifdef JLS_BYTEIZER_FRAME_CNT_EN
   ,
   output logic [31:0]   o_frame_bytes,
   output logic          o_frame_done
`endif
);

   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;

   logic [16:0]   mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic [16:0]   word;
   logic          full, nonempty, push, pop;
   state_t        state, state_nx;

   // Full is judged from the registered count, so a same-cycle pop never rescues a word.
   assign full     = (count == FULL_CNT);
   assign nonempty = (count != '0);
   assign push     = i_e & ~full;
   assign o_level  = count;

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      o_valid  = 1'b0;
      o_byte   = '0;
      o_last   = 1'b0;
      case (state)
         S_IDLE: begin
            if (nonempty) begin
               pop      = 1'b1;
               state_nx = S_HI;
            end
         end
         S_HI: begin
            o_valid = 1'b1;
            o_byte  = word[15:8];
            if (o_ready) state_nx = S_LO;
         end
         S_LO: begin
            o_valid = 1'b1;
            o_byte  = word[7:0];
            o_last  = word[16];
            if (o_ready) begin
               if (nonempty) begin
                  pop      = 1'b1;
                  state_nx = S_HI;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= {i_last, i_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         word       <= '0;
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else begin
         state <= state_nx;
         if (push) wptr <= wptr + 1'b1;
         if (pop) begin
            word <= mem[rptr];
            rptr <= rptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (i_e && full) o_overflow <= 1'b1;
      end
   end

`ifdef JLS_BYTEIZER_FRAME_CNT_EN
   logic [31:0] run_cnt;
   logic        accept;

   assign accept = o_valid & o_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt       <= '0;
         o_frame_bytes <= '0;
         o_frame_done  <= 1'b0;
      end else begin
         o_frame_done <= 1'b0;
         if (accept) begin
            if (o_last) begin
               o_frame_bytes <= run_cnt + 32'd1;
               o_frame_done  <= 1'b1;
               run_cnt       <= '0;
            end else begin
               run_cnt <= run_cnt + 32'd1;
            end
         end
      end
   end
`endif

endmodule
